// File: rtl/tff_seq_ctrl.sv
// tff_seq_ctrl -- sequencer for a bank of WIDTH toggle flip-flops.
//
// Every update of the bank is a toggle mask applied at the next edge:
// q <= q ^ t_vec. The bank can run as an up/down counter, either one-shot
// or continuous, with a programmable terminal value. The controller also
// supports start, pause and abort.
//
// Optional build macro: TFF_SEQ_GRAY_EN. When it is defined, q steps in
// reflected Gray code and limit is a Gray value. When it is undefined, the
// bank steps in binary and no Gray logic is built.
//
// Ports
//   clk    in  1      rising-edge clock
//   reset  in  1      synchronous, active-high; overrides all other inputs
//   start  in  1      IDLE: latch config, load and run; HOLD: resume
//   stop   in  1      RUN: pause; HOLD: abort to IDLE and clear q; wins over start
//   up_dn  in  1      direction, 1 = up; latched on start in IDLE
//   mode   in  1      0 = one-shot, 1 = continuous; latched on start in IDLE
//   limit  in  WIDTH  terminal value; latched on start in IDLE
//   t_vec  out WIDTH  combinational toggle mask for the next edge
//   q      out WIDTH  TFF bank state
//   busy   out 1      registered; high in RUN or HOLD
//   done   out 1      registered one-cycle pulse on one-shot completion
//   wrap   out 1      registered one-cycle pulse on continuous reload
//
// state | meaning
// IDLE  | waiting for start; q holds its last value
// RUN   | stepping q toward the terminal value
// HOLD  | paused; q frozen until resume or abort
// DONE  | one-shot finished; done is high for this cycle only
module tff_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             up_dn,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             run_up;
  logic             run_cont;
  logic [WIDTH-1:0] run_lim;
  logic             load_cfg;
  logic             wrap_set;
  logic             at_term;
  logic [WIDTH-1:0] step;

`ifdef TFF_SEQ_GRAY_EN
  // One-hot Gray step. Going up, even parity toggles bit 0. Going down, odd
  // parity toggles bit 0. Otherwise, toggle the bit left of the lowest set
  // bit. If the lowest set bit is the MSB, toggle the MSB itself. q == 0 is
  // never stepped downward because it is terminal, so a set bit always exists.
  always_comb begin : gray_step
    logic found;
    step  = '0;
    found = 1'b0;
    if ((^q) == ~run_up) begin
      step[0] = 1'b1;
    end else begin
      for (int i = 1; i < WIDTH; i++) begin
        if (!found && q[i-1]) begin
          step[i] = 1'b1;
          found   = 1'b1;
        end
      end
      if (!found) step[WIDTH-1] = 1'b1;
    end
  end
`else
  // Binary step. Bit i toggles when all lower bits are 1 (counting up) or
  // all lower bits are 0 (counting down).
  always_comb begin : bin_step
    logic carry;
    step  = '0;
    carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      step[i] = carry;
      carry   = carry & (run_up ? q[i] : ~q[i]);
    end
  end
`endif

  assign at_term = run_up ? (q == run_lim) : (q == '0);

  always_comb begin
    next_state = state;
    t_vec      = '0;
    load_cfg   = 1'b0;
    wrap_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          next_state = ST_RUN;
          load_cfg   = 1'b1;
          t_vec      = q ^ (up_dn ? '0 : limit);
        end
      end
      ST_RUN: begin
        // The terminal check comes before stepping. An up count with a
        // limit of 0 therefore finishes without any toggle.
        if (stop) begin
          next_state = ST_HOLD;
        end else if (at_term) begin
          if (run_cont) begin
            t_vec    = q ^ (run_up ? '0 : run_lim);
            wrap_set = 1'b1;
          end else begin
            next_state = ST_DONE;
          end
        end else begin
          t_vec = step;
        end
      end
      ST_HOLD: begin
        if (stop) begin
          next_state = ST_IDLE;
          t_vec      = q;
        end else if (start) begin
          next_state = ST_RUN;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      q        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wrap     <= 1'b0;
      run_up   <= 1'b0;
      run_cont <= 1'b0;
      run_lim  <= '0;
    end else begin
      state <= next_state;
      q     <= q ^ t_vec;
      busy  <= (next_state == ST_RUN) || (next_state == ST_HOLD);
      done  <= (next_state == ST_DONE);
      wrap  <= wrap_set;
      if (load_cfg) begin
        run_up   <= up_dn;
        run_cont <= mode;
        run_lim  <= limit;
      end
    end
  end

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// tb_tff_seq_ctrl -- self-checking bench for tff_seq_ctrl with WIDTH=4.
// The reference model tracks the count as a position index and converts it
// to the output code (binary, or Gray when TFF_SEQ_GRAY_EN is defined).
// The expected toggle mask is the XOR of the current and next code.
module tb_tff_seq_ctrl;
  localparam int W = 4;
  localparam int P_IDLE = 0, P_RUN = 1, P_HOLD = 2, P_DONE = 3;

  logic         clk = 1'b0;
  logic         reset, start, stop, up_dn, mode;
  logic [W-1:0] limit;
  logic [W-1:0] t_vec, q;
  logic         busy, done, wrap;

  always #5 clk = ~clk;

  tff_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .up_dn(up_dn),
    .mode(mode), .limit(limit), .t_vec(t_vec), .q(q), .busy(busy),
    .done(done), .wrap(wrap)
  );

  int n_cmp = 0;
  int n_err = 0;

  int           m_ph = P_IDLE, n_ph;
  logic [W-1:0] m_q = '0, m_lim = '0, n_q, n_lim, exp_t;
  logic         m_up = 1'b0, m_cont = 1'b0, n_up, n_cont;
  logic         m_busy = 1'b0, m_done = 1'b0, m_wrap = 1'b0, n_wrap;
  logic [2*W+2:0] exp_v, msk_v;

  function automatic logic [W-1:0] code(input int n);
    logic [W-1:0] b;
    b = n[W-1:0];
`ifdef TFF_SEQ_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  function automatic int index_of(input logic [W-1:0] c);
`ifdef TFF_SEQ_GRAY_EN
    logic [W-1:0] b;
    b[W-1] = c[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ c[i];
    return int'(b);
`else
    return int'(c);
`endif
  endfunction

  function automatic logic [2*W+2:0] got();
    return {t_vec, q, busy, done, wrap};
  endfunction

  task automatic model_eval();
    n_ph = m_ph; n_q = m_q; n_up = m_up; n_cont = m_cont; n_lim = m_lim; n_wrap = 1'b0;
    case (m_ph)
      P_IDLE: if (start && !stop) begin
        n_ph = P_RUN; n_up = up_dn; n_cont = mode; n_lim = limit;
        n_q = up_dn ? '0 : limit;
      end
      P_RUN: begin
        if (stop) n_ph = P_HOLD;
        else if (m_up ? (m_q == m_lim) : (m_q == '0)) begin
          if (m_cont) begin n_q = m_up ? '0 : m_lim; n_wrap = 1'b1; end
          else n_ph = P_DONE;
        end else n_q = code(index_of(m_q) + (m_up ? 1 : -1));
      end
      P_HOLD: begin
        if (stop) begin n_ph = P_IDLE; n_q = '0; end
        else if (start) n_ph = P_RUN;
      end
      default: n_ph = P_IDLE;
    endcase
    exp_t = m_q ^ n_q;
    if (reset) begin
      n_ph = P_IDLE; n_q = '0; n_up = 1'b0; n_cont = 1'b0; n_lim = '0; n_wrap = 1'b0;
    end
    exp_v = {exp_t, m_q, m_busy, m_done, m_wrap};
    msk_v = reset ? {{W{1'b0}}, {(W+3){1'b1}}} : '1;
  endtask

  task automatic set_in(input logic r, input logic s, input logic p, input logic u,
                        input logic md, input logic [W-1:0] l);
    reset = r; start = s; stop = p; up_dn = u; mode = md; limit = l;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_ph = n_ph; m_q = n_q; m_up = n_up; m_cont = n_cont; m_lim = n_lim;
    m_busy = (n_ph == P_RUN) || (n_ph == P_HOLD);
    m_done = (n_ph == P_DONE);
    m_wrap = n_wrap;
  endtask

  task automatic do_reset();
    set_in(1, 0, 0, 0, 0, '0);
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(1, 1, 0, 1, 1, 4'hF);
      n_cmp++;
      if ((got() & msk_v) !== (exp_v & msk_v)) begin
        n_err++; $display("FAIL reset_hold: got %b want %b", got() & msk_v, exp_v & msk_v);
      end
      tick();
    end
    set_in(0, 0, 0, 0, 0, '0);
    n_cmp++;
    if ({t_vec, q, busy, done, wrap} !== {(2*W+3){1'b0}}) begin
      n_err++; $display("FAIL reset_state: got %b want 0", {t_vec, q, busy, done, wrap});
    end
    tick();
  endtask

  task automatic test_up_oneshot();
    logic [W-1:0] tr[$];
    int ex[7] = '{0, 1, 2, 3, 4, 5, 5};
    int dn = 0, dn_at = -1;
    do_reset();
    set_in(0, 1, 0, 1, 0, code(5));
    tick();
    for (int c = 0; c < 10; c++) begin
      set_in(0, 0, 0, 0, 0, '0);
      n_cmp++;
      if (got() !== exp_v) begin
        n_err++; $display("FAIL up_oneshot cyc %0d: got %b want %b", c, got(), exp_v);
      end
      if (busy || done) tr.push_back(q);
      if (done) begin dn++; dn_at = tr.size() - 1; end
      tick();
    end
    n_cmp++;
    if (tr.size() != 7) begin
      n_err++; $display("FAIL up_oneshot_len: got %0d want 7", tr.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_cmp++;
        if (tr[i] !== code(ex[i])) begin
          n_err++; $display("FAIL up_oneshot_q[%0d]: got %b want %b", i, tr[i], code(ex[i]));
        end
      end
    end
    n_cmp++;
    if (dn != 1 || dn_at != 6 || q !== code(5) || busy !== 1'b0) begin
      n_err++; $display("FAIL up_oneshot_end: done %0d at %0d q %b busy %b want 1 at 6 q %b busy 0",
                        dn, dn_at, q, busy, code(5));
    end
  endtask

  task automatic test_down_cont();
    logic [W-1:0] tr[$];
    int ex[6] = '{3, 2, 1, 0, 3, 2};
    int wr_at = -1, nb = 0;
    do_reset();
    set_in(0, 1, 0, 0, 1, code(3));
    tick();
    for (int c = 0; c < 12; c++) begin
      set_in(0, 0, 0, 0, 0, '0);
      n_cmp++;
      if (got() !== exp_v) begin
        n_err++; $display("FAIL down_cont cyc %0d: got %b want %b", c, got(), exp_v);
      end
      tr.push_back(q);
      if (wrap && wr_at < 0) wr_at = c;
      if (!busy) nb++;
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (tr[i] !== code(ex[i])) begin
        n_err++; $display("FAIL down_cont_q[%0d]: got %b want %b", i, tr[i], code(ex[i]));
      end
    end
    n_cmp++;
    if (wr_at != 4 || nb != 0) begin
      n_err++; $display("FAIL down_cont_wrap: first wrap %0d not-busy %0d want 4 and 0", wr_at, nb);
    end
    set_in(0, 0, 1, 0, 0, '0); tick();
    set_in(0, 0, 1, 0, 0, '0); tick();
    set_in(0, 0, 0, 0, 0, '0);
    n_cmp++;
    if (q !== '0 || busy !== 1'b0) begin
      n_err++; $display("FAIL down_cont_abort: q %b busy %b want 0 0", q, busy);
    end
  endtask

`ifdef TFF_SEQ_GRAY_EN
  task automatic test_gray();
    logic [W-1:0] tr[$];
    logic [W-1:0] ex[5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
    int dn = 0, bad_hot = 0;
    do_reset();
    set_in(0, 1, 0, 1, 0, 4'b1000);
    tick();
    for (int c = 0; c < 20; c++) begin
      set_in(0, 0, 0, 0, 0, '0);
      n_cmp++;
      if (got() !== exp_v) begin
        n_err++; $display("FAIL gray cyc %0d: got %b want %b", c, got(), exp_v);
      end
      if (busy) tr.push_back(q);
      if (busy && t_vec != '0 && $countones(t_vec) != 1) bad_hot++;
      if (done) dn++;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (tr[i] !== ex[i]) begin
        n_err++; $display("FAIL gray_q[%0d]: got %b want %b", i, tr[i], ex[i]);
      end
    end
    n_cmp++;
    if (bad_hot != 0 || dn != 1 || q !== 4'b1000 || tr.size() != 16) begin
      n_err++; $display("FAIL gray_end: non-onehot %0d done %0d q %b steps %0d want 0 1 1000 16",
                        bad_hot, dn, q, tr.size());
    end
  endtask
`else
  task automatic test_carry();
    do_reset();
    set_in(0, 1, 0, 1, 1, 4'hF); tick();
    for (int c = 0; c < 7; c++) begin set_in(0, 0, 0, 0, 0, '0); tick(); end
    set_in(0, 0, 0, 0, 0, '0);
    n_cmp++;
    if (q !== 4'd7 || t_vec !== 4'b1111) begin
      n_err++; $display("FAIL carry_up: q %b t_vec %b want 0111 1111", q, t_vec);
    end
    tick();
    set_in(0, 0, 1, 0, 0, '0);
    n_cmp++;
    if (q !== 4'd8) begin n_err++; $display("FAIL carry_up_next: q %b want 1000", q); end
    tick();
    set_in(0, 0, 1, 0, 0, '0); tick();
    set_in(0, 1, 0, 0, 1, 4'h8); tick();
    set_in(0, 0, 0, 0, 0, '0);
    n_cmp++;
    if (q !== 4'd8 || t_vec !== 4'b1111) begin
      n_err++; $display("FAIL carry_dn: q %b t_vec %b want 1000 1111", q, t_vec);
    end
    tick();
    set_in(0, 0, 0, 0, 0, '0);
    n_cmp++;
    if (q !== 4'd7) begin n_err++; $display("FAIL carry_dn_next: q %b want 0111", q); end
    tick();
  endtask
`endif

  task automatic test_pause();
    do_reset();
    set_in(0, 1, 0, 1, 1, code(15)); tick();
    for (int c = 0; c < 2; c++) begin set_in(0, 0, 0, 0, 0, '0); tick(); end
    set_in(0, 0, 1, 0, 0, '0);
    n_cmp++;
    if (q !== code(2) || t_vec !== '0) begin
      n_err++; $display("FAIL pause_stop: q %b t_vec %b want %b 0000", q, t_vec, code(2));
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      set_in(0, 0, 0, 0, 0, '0);
      n_cmp++;
      if (q !== code(2) || t_vec !== '0 || busy !== 1'b1) begin
        n_err++; $display("FAIL pause_hold: q %b t_vec %b busy %b want %b 0000 1", q, t_vec, busy, code(2));
      end
      tick();
    end
    set_in(0, 1, 0, 0, 0, '0); tick();
    set_in(0, 0, 0, 0, 0, '0); tick();
    set_in(0, 0, 1, 0, 0, '0);
    n_cmp++;
    if (q !== code(3) || got() !== exp_v) begin
      n_err++; $display("FAIL pause_resume: q %b want %b (vec %b want %b)", q, code(3), got(), exp_v);
    end
    tick();
    set_in(0, 1, 1, 0, 0, '0);
    n_cmp++;
    if (t_vec !== code(3)) begin
      n_err++; $display("FAIL pause_abort_mask: t_vec %b want %b", t_vec, code(3));
    end
    tick();
    set_in(0, 0, 0, 0, 0, '0);
    n_cmp++;
    if (q !== '0 || busy !== 1'b0 || got() !== exp_v) begin
      n_err++; $display("FAIL pause_abort: q %b busy %b want 0 0", q, busy);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    set_in(0, 1, 0, 1, 1, code(15)); tick();
    for (int c = 0; c < 6; c++) begin set_in(0, 0, 0, 0, 0, '0); tick(); end
    set_in(1, 1, 1, 0, 0, '0);
    n_cmp++;
    if (q !== code(6) || busy !== 1'b1) begin
      n_err++; $display("FAIL midrun_pre: q %b busy %b want %b 1", q, busy, code(6));
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      set_in(0, 0, 0, 1, 1, 4'h9);
      n_cmp++;
      if ({q, busy, done, wrap} !== {(W+3){1'b0}} || got() !== exp_v) begin
        n_err++; $display("FAIL midrun_reset cyc %0d: got %b want %b", c, got(), exp_v);
      end
      tick();
    end
  endtask

  task automatic test_limit_zero();
    do_reset();
    set_in(0, 1, 0, 1, 0, '0); tick();
    set_in(0, 0, 0, 0, 0, '0);
    n_cmp++;
    if (t_vec !== '0 || busy !== 1'b1) begin
      n_err++; $display("FAIL limit0_run: t_vec %b busy %b want 0000 1", t_vec, busy);
    end
    tick();
    set_in(0, 1, 0, 1, 0, '0);
    n_cmp++;
    if (done !== 1'b1 || q !== '0 || t_vec !== '0) begin
      n_err++; $display("FAIL limit0_done: done %b q %b t_vec %b want 1 0000 0000", done, q, t_vec);
    end
    tick();
    set_in(0, 0, 0, 0, 0, '0);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL limit0_idle: done %b busy %b want 0 0", done, busy);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      set_in(0, 1, 0, 1, 0, code(2));
      n_cmp++;
      if (got() !== exp_v) begin
        n_err++; $display("FAIL back_to_back cyc %0d: got %b want %b", c, got(), exp_v);
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      set_in($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      n_cmp++;
      if ((got() & msk_v) !== (exp_v & msk_v)) begin
        n_err++; $display("FAIL random cyc %0d: got %b want %b", c, got() & msk_v, exp_v & msk_v);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_up_oneshot();
    test_down_cont();
`ifdef TFF_SEQ_GRAY_EN
    test_gray();
`else
    test_carry();
`endif
    test_pause();
    test_reset_mid_run();
    test_limit_zero();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
